// File: rtl/bluetooth_pen_axil_slave.sv
`default_nettype none
// ============================================================================
// Module   : bluetooth_pen_axil_slave
// Brief    : AXI4-Lite register slave for the Bluetooth_Pen peripheral.
//            NUM_REGS 32-bit registers with byte strobes, independent read and
//            write channels, a hardware-side write port, and a per-register
//            pulse on every committed AXI write.
//            Optional macro AXIL_SLVERR_EN: unmapped accesses return SLVERR.
// Revision : 1.0 - initial release
// ============================================================================
module bluetooth_pen_axil_slave #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_REGS   = 4
) (
   input  logic                             S_AXI_ACLK,
   input  logic                             S_AXI_ARESET,
   input  logic [ADDR_WIDTH-1:0]            S_AXI_AWADDR,
   input  logic [2:0]                       S_AXI_AWPROT,
   input  logic                             S_AXI_AWVALID,
   output logic                             S_AXI_AWREADY,
   input  logic [DATA_WIDTH-1:0]            S_AXI_WDATA,
   input  logic [DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
   input  logic                             S_AXI_WVALID,
   output logic                             S_AXI_WREADY,
   output logic [1:0]                       S_AXI_BRESP,
   output logic                             S_AXI_BVALID,
   input  logic                             S_AXI_BREADY,
   input  logic [ADDR_WIDTH-1:0]            S_AXI_ARADDR,
   input  logic [2:0]                       S_AXI_ARPROT,
   input  logic                             S_AXI_ARVALID,
   output logic                             S_AXI_ARREADY,
   output logic [DATA_WIDTH-1:0]            S_AXI_RDATA,
   output logic [1:0]                       S_AXI_RRESP,
   output logic                             S_AXI_RVALID,
   input  logic                             S_AXI_RREADY,
   output logic [NUM_REGS*DATA_WIDTH-1:0]   reg_out,
   output logic [NUM_REGS-1:0]              reg_wr_pulse,
   input  logic                             hw_we,
   input  logic [$clog2(NUM_REGS)-1:0]      hw_idx,
   input  logic [DATA_WIDTH-1:0]            hw_data
);

   localparam int IDX_W     = ADDR_WIDTH - 2;
   localparam int HW_IDX_W  = $clog2(NUM_REGS);
   localparam int NUM_BYTES = DATA_WIDTH / 8;

   localparam logic [1:0] c_RESP_OKAY = 2'b00;
`ifdef AXIL_SLVERR_EN
   localparam logic [1:0] c_RESP_UNMAPPED = 2'b10;
`else
   localparam logic [1:0] c_RESP_UNMAPPED = 2'b00;
`endif

   // Write-side holding state: address and data may arrive in any order
   logic                  r_aw_held;
   logic [IDX_W-1:0]      r_aw_idx;
   logic                  r_w_held;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [NUM_BYTES-1:0]  r_wstrb;

   // Response channels
   logic                  r_bvalid;
   logic [1:0]            r_bresp;
   logic                  r_rvalid;
   logic [1:0]            r_rresp;
   logic [DATA_WIDTH-1:0] r_rdata;

   // Register file and write pulses
   logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
   logic [NUM_REGS-1:0]   r_wr_pulse;

   logic                  w_aw_hs;
   logic                  w_w_hs;
   logic                  w_ar_hs;
   logic                  w_commit;
   logic                  w_aw_mapped;
   logic                  w_ar_mapped;
   logic [IDX_W-1:0]      w_ar_idx;
   logic [NUM_REGS-1:0]   w_wr_sel;
   logic [NUM_REGS-1:0]   w_hw_sel;
   logic [DATA_WIDTH-1:0] w_rd_data;

   // Protection bits and the byte offset within a word carry no meaning here
   logic w_unused;
   assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   // Ready signals depend only on registered state; a pending B response
   // blocks new write traffic so only one write is ever outstanding.
   assign S_AXI_AWREADY = ~r_aw_held & ~r_bvalid;
   assign S_AXI_WREADY  = ~r_w_held  & ~r_bvalid;
   assign S_AXI_ARREADY = ~r_rvalid;

   assign w_aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
   assign w_w_hs   = S_AXI_WVALID  & S_AXI_WREADY;
   assign w_ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
   assign w_commit = r_aw_held & r_w_held;

   assign w_ar_idx    = S_AXI_ARADDR[ADDR_WIDTH-1:2];
   assign w_aw_mapped = ({1'b0, r_aw_idx} < (IDX_W+1)'(NUM_REGS));
   assign w_ar_mapped = ({1'b0, w_ar_idx} < (IDX_W+1)'(NUM_REGS));

   assign S_AXI_BVALID = r_bvalid;
   assign S_AXI_BRESP  = r_bresp;
   assign S_AXI_RVALID = r_rvalid;
   assign S_AXI_RRESP  = r_rresp;
   assign S_AXI_RDATA  = r_rdata;
   assign reg_wr_pulse = r_wr_pulse;

   // Per-register decode: an AXI commit to a register masks a same-edge
   // hardware write to that register.
   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_dec
      assign w_wr_sel[gi] = w_commit && (r_aw_idx == IDX_W'(gi));
      assign w_hw_sel[gi] = hw_we && (hw_idx == HW_IDX_W'(gi)) && !w_wr_sel[gi];
      assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = r_regs[gi];
   end

   // Read mux; unmapped indices fall through to zero
   always_comb begin
      w_rd_data = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (w_ar_idx == IDX_W'(i)) begin
            w_rd_data = r_regs[i];
         end
      end
   end

   // Capture AW and W independently; release both on commit
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         r_aw_held <= 1'b0;
         r_aw_idx  <= '0;
         r_w_held  <= 1'b0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
      end else begin
         if (w_commit) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
         end
         if (w_aw_hs) begin
            r_aw_held <= 1'b1;
            r_aw_idx  <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
         end
         if (w_w_hs) begin
            r_w_held <= 1'b1;
            r_wdata  <= S_AXI_WDATA;
            r_wstrb  <= S_AXI_WSTRB;
         end
      end
   end

   // Write response: raised on commit, dropped on the B handshake
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         r_bvalid   <= 1'b0;
         r_bresp    <= c_RESP_OKAY;
         r_wr_pulse <= '0;
      end else begin
         r_wr_pulse <= w_wr_sel;
         if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_aw_mapped ? c_RESP_OKAY : c_RESP_UNMAPPED;
         end else if (r_bvalid && S_AXI_BREADY) begin
            r_bvalid <= 1'b0;
         end
      end
   end

   // Register file: byte-strobed AXI writes take priority over hardware writes
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (w_wr_sel[i]) begin
               for (int b = 0; b < NUM_BYTES; b++) begin
                  if (r_wstrb[b]) begin
                     r_regs[i][8*b +: 8] <= r_wdata[8*b +: 8];
                  end
               end
            end else if (w_hw_sel[i]) begin
               r_regs[i] <= hw_data;
            end
         end
      end
   end

   // Read channel: sample the pre-edge register value on the AR handshake
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         r_rvalid <= 1'b0;
         r_rresp  <= c_RESP_OKAY;
         r_rdata  <= '0;
      end else begin
         if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_ar_mapped ? c_RESP_OKAY : c_RESP_UNMAPPED;
         end else if (r_rvalid && S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bluetooth_pen_axil_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_bluetooth_pen_axil_slave
// Brief    : Directed self-checking bench for bluetooth_pen_axil_slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bluetooth_pen_axil_slave;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [4:0]  araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [127:0] reg_out;
   logic [3:0]  reg_wr_pulse;
   logic        hw_we;
   logic [1:0]  hw_idx;
   logic [31:0] hw_data;

`ifdef AXIL_SLVERR_EN
   localparam logic [1:0] EXP_UNMAPPED = 2'b10;
`else
   localparam logic [1:0] EXP_UNMAPPED = 2'b00;
`endif

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] exp_regs [4];
   logic [1:0]  resp;
   logic [3:0]  pulse;
   logic [31:0] d;

   always #5 clk = ~clk;

   bluetooth_pen_axil_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(4)) dut (
      .S_AXI_ACLK   (clk),
      .S_AXI_ARESET (rst),
      .S_AXI_AWADDR (awaddr),
      .S_AXI_AWPROT (awprot),
      .S_AXI_AWVALID(awvalid),
      .S_AXI_AWREADY(awready),
      .S_AXI_WDATA  (wdata),
      .S_AXI_WSTRB  (wstrb),
      .S_AXI_WVALID (wvalid),
      .S_AXI_WREADY (wready),
      .S_AXI_BRESP  (bresp),
      .S_AXI_BVALID (bvalid),
      .S_AXI_BREADY (bready),
      .S_AXI_ARADDR (araddr),
      .S_AXI_ARPROT (arprot),
      .S_AXI_ARVALID(arvalid),
      .S_AXI_ARREADY(arready),
      .S_AXI_RDATA  (rdata),
      .S_AXI_RRESP  (rresp),
      .S_AXI_RVALID (rvalid),
      .S_AXI_RREADY (rready),
      .reg_out      (reg_out),
      .reg_wr_pulse (reg_wr_pulse),
      .hw_we        (hw_we),
      .hw_idx       (hw_idx),
      .hw_data      (hw_data)
   );

   // Full AXI write; returns BRESP and the reg_wr_pulse seen with BVALID
   task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                            input logic [3:0] strb,
                            output logic [1:0] r, output logic [3:0] p);
      bit aw_done, w_done, aw_hs, w_hs;
      int n;
      aw_done = 0; w_done = 0; n = 0;
      @(negedge clk);
      awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1; bready = 1'b1;
      while (!(aw_done && w_done) && n < 20) begin
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         @(negedge clk);
         if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
         if (w_hs)  begin wvalid  = 1'b0; w_done  = 1; end
         n++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      n = 0;
      while (!bvalid && n < 20) begin @(negedge clk); n++; end
      r = bresp; p = reg_wr_pulse;
      if (!bvalid) begin
         vectors++; miscompares++;
         $display("FAIL write_timeout addr=%h: bvalid=%b required 1", addr, bvalid);
      end
      @(negedge clk);
   endtask

   // Full AXI read; returns RDATA and RRESP
   task automatic axi_read(input logic [4:0] addr, output logic [31:0] dat, output logic [1:0] r);
      bit done, hs;
      int n;
      done = 0; n = 0;
      @(negedge clk);
      araddr = addr; arvalid = 1'b1; rready = 1'b1;
      while (!done && n < 20) begin
         hs = arvalid && arready;
         @(negedge clk);
         if (hs) begin arvalid = 1'b0; done = 1; end
         n++;
      end
      arvalid = 1'b0;
      dat = rdata; r = rresp;
      if (!done || !rvalid) begin
         vectors++; miscompares++;
         $display("FAIL read_timeout addr=%h: rvalid=%b required 1", addr, rvalid);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
      araddr = '0; arprot = '0; arvalid = 0; rready = 0; hw_we = 0; hw_idx = '0; hw_data = '0;
      for (int i = 0; i < 4; i++) exp_regs[i] = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      vectors++; if ({awready, wready, arready} !== 3'b111) begin miscompares++;
         $display("FAIL reset_ready: got %b required 111", {awready, wready, arready}); end
      vectors++; if ({bvalid, rvalid} !== 2'b00) begin miscompares++;
         $display("FAIL reset_valid: got %b required 00", {bvalid, rvalid}); end
      vectors++; if (reg_out !== 128'h0) begin miscompares++;
         $display("FAIL reset_regs: got %h required 0", reg_out); end
      vectors++; if ({reg_wr_pulse, bresp, rresp, rdata} !== 40'h0) begin miscompares++;
         $display("FAIL reset_outputs: got %h required 0", {reg_wr_pulse, bresp, rresp, rdata}); end
   endtask

   task automatic test_seq_writes();
      for (int i = 0; i < 4; i++) begin
         axi_write(5'(i*4), 32'(i+1), 4'hF, resp, pulse);
         exp_regs[i] = 32'(i+1);
         vectors++; if (resp !== 2'b00) begin miscompares++;
            $display("FAIL seq_bresp[%0d]: got %b required 00", i, resp); end
         vectors++; if (pulse !== 4'(1 << i)) begin miscompares++;
            $display("FAIL seq_pulse[%0d]: got %b required %b", i, pulse, 4'(1 << i)); end
      end
      for (int i = 0; i < 4; i++) begin
         axi_read(5'(i*4), d, resp);
         vectors++; if (d !== 32'(i+1)) begin miscompares++;
            $display("FAIL seq_rdata[%0d]: got %h required %h", i, d, 32'(i+1)); end
         vectors++; if (resp !== 2'b00) begin miscompares++;
            $display("FAIL seq_rresp[%0d]: got %b required 00", i, resp); end
      end
   endtask

   task automatic test_strobes();
      axi_write(5'h04, 32'hAABBCCDD, 4'hF, resp, pulse);
      axi_write(5'h04, 32'h11223344, 4'b0101, resp, pulse);
      exp_regs[1] = 32'hAA22CC44;
      axi_read(5'h04, d, resp);
      vectors++; if (d !== 32'hAA22CC44) begin miscompares++;
         $display("FAIL strobe_merge: got %h required AA22CC44", d); end
   endtask

   task automatic test_aw_early_b_stall();
      @(negedge clk);
      bready = 1'b0; awaddr = 5'h08; awvalid = 1'b1; wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b0;
      vectors++; if (awready !== 1'b1) begin miscompares++;
         $display("FAIL stall_awready_idle: got %b required 1", awready); end
      @(negedge clk);
      awvalid = 1'b0;
      vectors++; if ({awready, wready} !== 2'b01) begin miscompares++;
         $display("FAIL stall_aw_held: awready/wready got %b required 01", {awready, wready}); end
      repeat (2) @(negedge clk);
      wvalid = 1'b1;
      @(negedge clk);
      wvalid = 1'b0;
      vectors++; if (bvalid !== 1'b0) begin miscompares++;
         $display("FAIL stall_bvalid_early: got %b required 0", bvalid); end
      @(negedge clk);
      vectors++; if ({bvalid, bresp, reg_wr_pulse} !== 7'b1_00_0100) begin miscompares++;
         $display("FAIL stall_commit: bvalid/bresp/pulse got %b required 1000100",
                  {bvalid, bresp, reg_wr_pulse}); end
      exp_regs[2] = 32'h77;
      awaddr = 5'h0C; awvalid = 1'b1; wdata = 32'hFFFF_FFFF;
      for (int i = 0; i < 5; i++) begin
         vectors++; if ({bvalid, awready, wready} !== 3'b100) begin miscompares++;
            $display("FAIL stall_hold[%0d]: bvalid/awready/wready got %b required 100", i,
                     {bvalid, awready, wready}); end
         @(negedge clk);
      end
      awvalid = 1'b0; bready = 1'b1;
      vectors++; if (bvalid !== 1'b1) begin miscompares++;
         $display("FAIL stall_bvalid_hold: got %b required 1", bvalid); end
      @(negedge clk);
      vectors++; if ({bvalid, awready} !== 2'b01) begin miscompares++;
         $display("FAIL stall_release: bvalid/awready got %b required 01", {bvalid, awready}); end
      axi_read(5'h08, d, resp);
      vectors++; if (d !== 32'h77) begin miscompares++;
         $display("FAIL stall_rdata: got %h required 00000077", d); end
      vectors++; if (reg_out[127:96] !== exp_regs[3]) begin miscompares++;
         $display("FAIL stall_reg3: got %h required %h", reg_out[127:96], exp_regs[3]); end
   endtask

   task automatic test_hw_collision();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         bready = 1'b1; awaddr = 5'h08; awvalid = 1'b1; wdata = 32'h5; wstrb = 4'hF; wvalid = 1'b1;
         vectors++; if ({awready, wready} !== 2'b11) begin miscompares++;
            $display("FAIL hw_ready[%0d]: got %b required 11", c, {awready, wready}); end
         @(negedge clk);
         awvalid = 1'b0; wvalid = 1'b0;
         hw_we = 1'b1; hw_idx = (c == 0) ? 2'd2 : 2'd3; hw_data = 32'h9;
         @(negedge clk);
         hw_we = 1'b0;
         exp_regs[2] = 32'h5;
         if (c == 1) exp_regs[3] = 32'h9;
         vectors++; if ({bvalid, reg_wr_pulse} !== 5'b1_0100) begin miscompares++;
            $display("FAIL hw_commit[%0d]: bvalid/pulse got %b required 10100", c,
                     {bvalid, reg_wr_pulse}); end
         vectors++; if (reg_out[95:64] !== 32'h5) begin miscompares++;
            $display("FAIL hw_reg2[%0d]: got %h required 00000005", c, reg_out[95:64]); end
         vectors++; if (reg_out[127:96] !== exp_regs[3]) begin miscompares++;
            $display("FAIL hw_reg3[%0d]: got %h required %h", c, reg_out[127:96], exp_regs[3]); end
         @(negedge clk);
         vectors++; if (bvalid !== 1'b0) begin miscompares++;
            $display("FAIL hw_bdone[%0d]: got %b required 0", c, bvalid); end
      end
      @(negedge clk);
      hw_we = 1'b1; hw_idx = 2'd0; hw_data = 32'hDEADBEEF;
      @(negedge clk);
      hw_we = 1'b0;
      exp_regs[0] = 32'hDEADBEEF;
      vectors++; if (reg_out[31:0] !== 32'hDEADBEEF) begin miscompares++;
         $display("FAIL hw_only_reg0: got %h required DEADBEEF", reg_out[31:0]); end
      vectors++; if (reg_wr_pulse !== 4'b0000) begin miscompares++;
         $display("FAIL hw_only_pulse: got %b required 0000", reg_wr_pulse); end
   endtask

   task automatic test_unmapped();
      axi_write(5'h10, 32'hFFFF_FFFF, 4'hF, resp, pulse);
      vectors++; if (resp !== EXP_UNMAPPED) begin miscompares++;
         $display("FAIL unmapped_bresp: got %b required %b", resp, EXP_UNMAPPED); end
      vectors++; if (pulse !== 4'b0000) begin miscompares++;
         $display("FAIL unmapped_pulse: got %b required 0000", pulse); end
      axi_read(5'h10, d, resp);
      vectors++; if ({d, resp} !== {32'h0, EXP_UNMAPPED}) begin miscompares++;
         $display("FAIL unmapped_read: got %h/%b required 0/%b", d, resp, EXP_UNMAPPED); end
      axi_read(5'h1C, d, resp);
      vectors++; if ({d, resp} !== {32'h0, EXP_UNMAPPED}) begin miscompares++;
         $display("FAIL unmapped_read_top: got %h/%b required 0/%b", d, resp, EXP_UNMAPPED); end
      vectors++; if (reg_out !== {exp_regs[3], exp_regs[2], exp_regs[1], exp_regs[0]}) begin
         miscompares++;
         $display("FAIL unmapped_regs: got %h required %h", reg_out,
                  {exp_regs[3], exp_regs[2], exp_regs[1], exp_regs[0]}); end
   endtask

   task automatic test_reset_mid();
      // Reset while a B response is pending
      @(negedge clk);
      bready = 1'b0; awaddr = 5'h04; awvalid = 1'b1; wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      vectors++; if (bvalid !== 1'b1) begin miscompares++;
         $display("FAIL rstmid_bvalid_pre: got %b required 1", bvalid); end
      #2 rst = 1'b1;
      #1;
      vectors++; if ({bvalid, reg_wr_pulse} !== 5'b0) begin miscompares++;
         $display("FAIL rstmid_bvalid_async: bvalid/pulse got %b required 00000",
                  {bvalid, reg_wr_pulse}); end
      vectors++; if (reg_out !== 128'h0) begin miscompares++;
         $display("FAIL rstmid_regs_clear: got %h required 0", reg_out); end
      @(negedge clk);
      rst = 1'b0; bready = 1'b1;
      // Reset while only the address is held
      @(negedge clk);
      awaddr = 5'h00; awvalid = 1'b1; wdata = 32'hCAFE; wvalid = 1'b0;
      @(negedge clk);
      awvalid = 1'b0;
      vectors++; if (awready !== 1'b0) begin miscompares++;
         $display("FAIL rstmid_aw_held: awready got %b required 0", awready); end
      #2 rst = 1'b1;
      #1;
      vectors++; if (awready !== 1'b1) begin miscompares++;
         $display("FAIL rstmid_aw_cleared: awready got %b required 1", awready); end
      @(negedge clk);
      rst = 1'b0;
      // Data alone must not pair with the abandoned address
      @(negedge clk);
      wdata = 32'h1234; wstrb = 4'hF; wvalid = 1'b1;
      @(negedge clk);
      wvalid = 1'b0;
      repeat (4) @(negedge clk);
      vectors++; if ({bvalid, reg_wr_pulse} !== 5'b0) begin miscompares++;
         $display("FAIL rstmid_no_commit: bvalid/pulse got %b required 00000",
                  {bvalid, reg_wr_pulse}); end
      vectors++; if (reg_out !== 128'h0) begin miscompares++;
         $display("FAIL rstmid_regs: got %h required 0", reg_out); end
      axi_read(5'h00, d, resp);
      vectors++; if (d !== 32'h0) begin miscompares++;
         $display("FAIL rstmid_read0: got %h required 0", d); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_seq_writes();
      test_strobes();
      test_aw_early_b_stall();
      test_hw_collision();
      test_unmapped();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bluetooth_pen_axil_slave.md
Name: bluetooth_pen_axil_slave

Overview:
AXI4-Lite responder that terminates the S00_AXI port of the Bluetooth_Pen peripheral. The bus master is the PS or a master VIP. The block holds NUM_REGS 32-bit control/status registers, supports byte-lane strobes and independent read/write channels, and exposes the registers to pen logic. Pen logic can also update a register from the hardware side.

Parameters:
DATA_WIDTH, 32, AXI data width; only 32 is supported.
ADDR_WIDTH, 5, AXI byte-address width; word index = addr[ADDR_WIDTH-1:2].
NUM_REGS, 4, number of implemented registers at word indices 0..NUM_REGS-1; must be ≤ 2^(ADDR_WIDTH-2).

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESET  in  1  asynchronous reset, active-high
S_AXI_AWADDR  in  ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake
S_AXI_BRESP  out  2  write response
S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake
S_AXI_ARADDR  in  ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake
reg_out  out  NUM_REGS*32  current register contents, reg i at [32i+31:32i]
reg_wr_pulse  out  NUM_REGS  one-cycle pulse when an AXI write commits to reg i
hw_we  in  1  hardware-side write enable
hw_idx  in  clog2(NUM_REGS)  hardware-side target register
hw_data  in  32  hardware-side write data, full word

Behaviour:
- Reset (async assert, sync release) clears:
  - all registers
  - BVALID, RVALID, BRESP, RRESP, RDATA, reg_wr_pulse
  - AW and W holding flags
- AWREADY = ~aw_held & ~BVALID; WREADY = ~w_held & ~BVALID. Both are combinational from registered state only.
- AW and W are accepted in any order or in the same cycle. Address and data/strobe are latched and the matching held flag is set.
- Commit occurs on the first edge where aw_held & w_held are both true at the start of the cycle:
  - bytes with WSTRB=1 are written
  - BVALID is set and BRESP=OKAY
  - held flags are cleared
  - reg_wr_pulse[idx] is set for exactly one cycle
- Minimum write latency: AW+W handshake at edge k, commit and BVALID at edge k+1.
- BVALID holds until the BREADY handshake. No AW/W is accepted while BVALID=1, so at most one write is outstanding.
- ARREADY = ~RVALID. On the AR handshake at edge k:
  - RDATA is loaded with the register value as it stood before edge k
  - RVALID=1 at k, RRESP=OKAY
  - RDATA/RVALID hold until RREADY
- Read/write same register, same edge: the read returns the pre-commit value.
- hw_we writes hw_data to reg[hw_idx] at the edge.
  - If an AXI commit targets the same register on the same edge, the AXI write wins and the hw write is dropped.
  - Different registers: both take effect.
  - hw writes never pulse reg_wr_pulse.
- Unimplemented index (≥ NUM_REGS), feature off: writes are discarded with BRESP=OKAY; reads return 0 with OKAY.
- Reset mid-transaction: the transaction is abandoned with no response issued. The master must reissue after release.

Optional Feature:
AXIL_SLVERR_EN
- Defined: an access to an unimplemented index returns SLVERR (2'b10) on BRESP/RRESP. Writes are discarded; reads return 0.
- Undefined: OKAY is returned as above.

Test Plan:
- Four sequential writes of 1,2,3,4 to 0x00,0x04,0x08,0x0C (WSTRB=F), then four reads -> reads return 1,2,3,4, all OKAY; reg_wr_pulse shows 4'b0001,0010,0100,1000 in turn.
- Write 0xAABBCCDD to 0x04, then write 0x11223344 with WSTRB=4'b0101 -> read 0x04 = 0xAA22CC44.
- AWVALID asserted 3 cycles before WVALID, BREADY held low 5 cycles:
  - AWREADY drops after the AW handshake
  - BVALID is asserted 1 cycle after the W handshake and held for 5 cycles
  - no new AW is accepted until B completes
- Same edge: AXI commit to reg 2 = 0x5 and hw_we to idx 2 = 0x9; a second case with hw_idx 3 = 0x9 -> first case reg2=0x5 (hw write dropped); second case reg2=0x5 and reg3=0x9.
- Access to 0x10, feature on and off -> on: BRESP/RRESP=2'b10 with RDATA=0; off: OKAY with RDATA=0; registers 0..3 unchanged in both.
- Reset asserted while BVALID=1 and while aw_held=1 -> BVALID=0 immediately; the held write never commits after release and register contents read 0.
